load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Read-side counterpart of the store formatter: takes a load command (LB/LH/LW/LBU/LHU) and a byte address from the execute stage.
- Issues one word read to data memory over a req/gnt/rvalid handshake, then selects the byte lane and sign- or zero-extends the result.
- Returns one registered result with a single-cycle valid pulse to writeback.
- Sits between the LSU decode and the data-memory port.

Parameters:
- ADDR_W, 32, address width of ld_addr and mem_addr.
- TIMEOUT, 15, max cycles spent waiting in WAIT for mem_rvalid before flagging an error; must be ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lb_en  input  1  load byte, sign-extend.
- lh_en  input  1  load half, sign-extend.
- lw_en  input  1  load word.
- lbu_en  input  1  load byte, zero-extend.
- lhu_en  input  1  load half, zero-extend.
- ld_addr  input  ADDR_W  byte address of the load.
- ld_ready  output  1  unit can accept a command this cycle.
- mem_req  output  1  read request to memory.
- mem_addr  output  ADDR_W  word-aligned read address, ld_addr with [1:0] forced to 0.
- mem_gnt  input  1  memory accepted the request.
- mem_rvalid  input  1  mem_rdata valid.
- mem_rdata  input  32  read word, little-endian.
- load_data  output  32  extended result.
- load_valid  output  1  one-cycle pulse, load_data valid.
- load_err  output  1  one-cycle pulse: illegal command, timeout, or misaligned access (see Optional Feature).

Behaviour:
- Reset: state=IDLE. ld_ready=1. mem_req=0, mem_addr=0, load_data=0, load_valid=0, load_err=0. Timeout counter=0. Reset asserted mid-transaction aborts it silently; an rvalid arriving after reset deasserts is ignored in IDLE.
- State IDLE: ld_ready=1.
  - Exactly one enable high: capture ld_addr[1:0] and the 3-bit op code, register mem_addr, go to REQ.
  - More than one enable high: no memory access; load_err pulses next cycle; stay IDLE.
  - No enable high: idle.
- State REQ: mem_req=1. mem_addr is held stable until mem_gnt. On mem_gnt go to WAIT and clear the counter.
- State WAIT: mem_req=0.
  - mem_rvalid: register the extracted result, pulse load_valid next cycle, go to IDLE.
  - No mem_rvalid: increment the counter. When the counter reaches TIMEOUT, pulse load_err with load_data=0 and go to IDLE.
  - mem_rvalid in the same cycle the counter hits TIMEOUT: the data wins, no error.
- mem_rvalid outside WAIT is ignored. ld_ready=0 in REQ and WAIT; enables are ignored there.
- Minimum latency: command accepted at edge N, mem_req high in cycle N+1, gnt in N+1, rvalid in N+2, load_valid in N+3. Throughput is one load per 3 cycles at best.
- Extraction, off = captured addr[1:0]:
  - Byte = mem_rdata[8*off+7 : 8*off].
  - Half = mem_rdata[16*off[1]+15 : 16*off[1]].
  - LB/LH replicate the MSB into the upper bits; LBU/LHU fill the upper bits with 0; LW passes the word through.
- load_data holds its value between pulses. load_valid and load_err are never high together.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined: LH/LHU with off[0]=1, or LW with off≠0, issues no memory request. load_err pulses the cycle after acceptance and the unit stays IDLE.
- Undefined: for halves, off[0] is ignored and the half is taken from off[1]; LW ignores off. Such loads complete normally with no error.

Decomposition:
- Shared package load_pkg:
  - State enum: IDLE, REQ, WAIT.
  - Op-code localparams: OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU.
  - Function for the one-hot legality check.
- Sub-module load_extract: purely combinational lane select and sign/zero extend (op, off, rdata -> data). It is reusable by the verification reference model.

Test Plan:
- LB at addr 0x103, rdata 0x80FF_1234, gnt immediate, rvalid next cycle -> load_data 0xFFFF_FF80, load_valid at cycle N+3, mem_addr 0x100.
- LBU/LHU at addr 0x102, rdata 0x8765_4321 -> 0x0000_0065 and 0x0000_8765; LH on the same data -> 0xFFFF_8765.
- LW at 0x200 with gnt held low 4 cycles -> mem_req and mem_addr stable all 4 cycles, then result 0x8765_4321 after rvalid.
- lb_en and lw_en high together -> no mem_req, load_err pulse, ld_ready stays 1.
- No rvalid for TIMEOUT=15 cycles -> load_err pulse, load_data 0, back to IDLE. A second run with rvalid on cycle 15 returns data and no error.
- LH at 0x101: macro defined -> load_err, no mem_req. Macro undefined -> half from bits [15:0]. Also assert rst during WAIT -> all outputs return to reset values, and a later rvalid produces no load_valid.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types, op codes and command-decode helpers for the load unit.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_LHU = 3'd5;

    // en is packed {lhu, lbu, lw, lh, lb}; legal only when exactly one bit is set.
    function automatic logic one_hot5(input logic [4:0] en);
        return (en != 5'b0) && ((en & (en - 5'd1)) == 5'b0);
    endfunction

    function automatic logic [2:0] encode_op(input logic [4:0] en);
        logic [2:0] op;
        op = OP_LB;
        if (en[1]) op = OP_LH;
        if (en[2]) op = OP_LW;
        if (en[3]) op = OP_LBU;
        if (en[4]) op = OP_LHU;
        return op;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane select and sign/zero extension of a little-endian read word.
module load_extract
    import load_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'b0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: one word read over req/gnt/rvalid, then lane extract and extend to writeback.
// Define LOAD_MISALIGN_TRAP_EN to reject misaligned LH/LHU/LW with load_err instead of issuing them.
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lb_en,
    input  logic              lh_en,
    input  logic              lw_en,
    input  logic              lbu_en,
    input  logic              lhu_en,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              load_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t           state, state_nxt;
    logic [2:0]       op_p0;
    logic [1:0]       off_p0;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       en;
    logic [2:0]       op_in;
    logic             misalign, accept, reject, timeout_hit;
    logic [31:0]      ext_data;

    assign en    = {lhu_en, lbu_en, lw_en, lh_en, lb_en};
    assign op_in = encode_op(en);

`ifdef LOAD_MISALIGN_TRAP_EN
    assign misalign = (((op_in == OP_LH) || (op_in == OP_LHU)) && ld_addr[0]) ||
                      ((op_in == OP_LW) && (ld_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Any command that is seen in IDLE but cannot be issued becomes a one-cycle error.
    assign accept      = (state == IDLE) && one_hot5(en) && !misalign;
    assign reject      = (state == IDLE) && (en != 5'b0) && !accept;
    assign timeout_hit = (state == WAIT) && !mem_rvalid && (cnt == CNT_W'(TIMEOUT - 1));

    load_extract u_extract (
        .op    (op_p0),
        .off   (off_p0),
        .rdata (mem_rdata),
        .data  (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                ld_ready = 1'b1;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, wait counter and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= '0;
            op_p0      <= OP_LB;
            off_p0     <= 2'b00;
            cnt        <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            load_err   <= reject;
            if (accept) begin
                mem_addr <= {ld_addr[ADDR_W-1:2], 2'b00};
                op_p0    <= op_in;
                off_p0   <= ld_addr[1:0];
            end
            if ((state == REQ) && mem_gnt) cnt <= '0;
            if (state == WAIT) begin
                if (mem_rvalid) begin
                    load_data  <= ext_data;
                    load_valid <= 1'b1;
                end else if (timeout_hit) begin
                    load_data <= '0;
                    load_err  <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit with hand-computed expected results.
module tb_load_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lb_en = 1'b0, lh_en = 1'b0, lw_en = 1'b0, lbu_en = 1'b0, lhu_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] EN_LB  = 5'b00001;
    localparam logic [4:0] EN_LH  = 5'b00010;
    localparam logic [4:0] EN_LW  = 5'b00100;
    localparam logic [4:0] EN_LBU = 5'b01000;
    localparam logic [4:0] EN_LHU = 5'b10000;

    load_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .lb_en      (lb_en),
        .lh_en      (lh_en),
        .lw_en      (lw_en),
        .lbu_en     (lbu_en),
        .lhu_en     (lhu_en),
        .ld_addr    (ld_addr),
        .ld_ready   (ld_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic [4:0] en);
        {lhu_en, lbu_en, lw_en, lh_en, lb_en} = en;
    endtask

    // rv_wait = WAIT cycles without rvalid; rv_wait >= TIMEOUT expects the timeout error.
    task automatic run_load(input string tag, input logic [4:0] en, input logic [31:0] addr,
                            input int gnt_wait, input int rv_wait,
                            input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] aligned;
        aligned = {addr[31:2], 2'b00};
        check({tag, ":ready_idle"}, {31'b0, ld_ready}, 32'd1);
        set_en(en);
        ld_addr = addr;
        step();
        set_en(5'b0);
        ld_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < gnt_wait; i++) begin
            check({tag, ":req_hold"}, {31'b0, mem_req}, 32'd1);
            check({tag, ":addr_hold"}, mem_addr, aligned);
            step();
        end
        check({tag, ":req"}, {31'b0, mem_req}, 32'd1);
        check({tag, ":addr"}, mem_addr, aligned);
        check({tag, ":ready_busy"}, {31'b0, ld_ready}, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < rv_wait && i < TIMEOUT; i++) begin
            check({tag, ":req_wait"}, {31'b0, mem_req}, 32'd0);
            step();
        end
        if (rv_wait < TIMEOUT) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step();
            mem_rvalid = 1'b0;
            check({tag, ":valid"}, {31'b0, load_valid}, 32'd1);
            check({tag, ":err"}, {31'b0, load_err}, 32'd0);
            check({tag, ":data"}, load_data, exp);
        end else begin
            check({tag, ":to_err"}, {31'b0, load_err}, 32'd1);
            check({tag, ":to_valid"}, {31'b0, load_valid}, 32'd0);
            check({tag, ":to_data"}, load_data, 32'd0);
        end
        step();
        check({tag, ":valid_pulse"}, {31'b0, load_valid}, 32'd0);
        check({tag, ":err_pulse"}, {31'b0, load_err}, 32'd0);
        check({tag, ":ready_back"}, {31'b0, ld_ready}, 32'd1);
    endtask

    // Command that must be refused in IDLE: no request, one error pulse.
    task automatic run_reject(input string tag, input logic [4:0] en, input logic [31:0] addr);
        set_en(en);
        ld_addr = addr;
        step();
        set_en(5'b0);
        check({tag, ":no_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, ":err"}, {31'b0, load_err}, 32'd1);
        check({tag, ":valid"}, {31'b0, load_valid}, 32'd0);
        check({tag, ":ready"}, {31'b0, ld_ready}, 32'd1);
        step();
        check({tag, ":err_pulse"}, {31'b0, load_err}, 32'd0);
        check({tag, ":still_idle"}, {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        repeat (2) step();
        check("rst:ready", {31'b0, ld_ready}, 32'd1);
        check("rst:req", {31'b0, mem_req}, 32'd0);
        check("rst:addr", mem_addr, 32'd0);
        check("rst:data", load_data, 32'd0);
        check("rst:valid", {31'b0, load_valid}, 32'd0);
        check("rst:err", {31'b0, load_err}, 32'd0);
        rst = 1'b0;
        step();

        run_load("lb_103", EN_LB, 32'h0000_0103, 0, 0, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("lbu_102", EN_LBU, 32'h0000_0102, 0, 0, 32'h8765_4321, 32'h0000_0065);
        run_load("lhu_102", EN_LHU, 32'h0000_0102, 0, 0, 32'h8765_4321, 32'h0000_8765);
        run_load("lh_102", EN_LH, 32'h0000_0102, 0, 0, 32'h8765_4321, 32'hFFFF_8765);
        run_load("lh_100", EN_LH, 32'h0000_0100, 0, 0, 32'h8765_4321, 32'h0000_4321);
        run_load("lb_101", EN_LB, 32'h0000_0101, 0, 2, 32'h8765_4321, 32'h0000_0043);
        run_load("lw_200", EN_LW, 32'h0000_0200, 4, 0, 32'h8765_4321, 32'h8765_4321);

        run_reject("multi_en", EN_LB | EN_LW, 32'h0000_0040);

        run_load("timeout", EN_LW, 32'h0000_0300, 0, TIMEOUT, 32'h1111_1111, 32'h0);
        run_load("rv_last", EN_LW, 32'h0000_0304, 0, TIMEOUT - 1, 32'hCAFE_F00D, 32'hCAFE_F00D);

`ifdef LOAD_MISALIGN_TRAP_EN
        run_reject("lh_101_trap", EN_LH, 32'h0000_0101);
        run_reject("lw_202_trap", EN_LW, 32'h0000_0202);
`else
        run_load("lh_101", EN_LH, 32'h0000_0101, 0, 0, 32'h1234_C0DE, 32'hFFFF_C0DE);
        run_load("lw_203", EN_LW, 32'h0000_0203, 0, 0, 32'h1234_C0DE, 32'h1234_C0DE);
`endif

        // Reset while waiting for read data, then a stray rvalid must be ignored.
        set_en(EN_LW);
        ld_addr = 32'h0000_0400;
        step();
        set_en(5'b0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst:req", {31'b0, mem_req}, 32'd0);
        check("midrst:addr", mem_addr, 32'd0);
        check("midrst:data", load_data, 32'd0);
        check("midrst:valid", {31'b0, load_valid}, 32'd0);
        check("midrst:err", {31'b0, load_err}, 32'd0);
        check("midrst:ready", {31'b0, ld_ready}, 32'd1);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        step();
        mem_rvalid = 1'b0;
        check("stray_rv:valid", {31'b0, load_valid}, 32'd0);
        check("stray_rv:data", load_data, 32'd0);
        check("stray_rv:ready", {31'b0, ld_ready}, 32'd1);

        run_load("after_rst", EN_LBU, 32'h0000_0503, 0, 0, 32'hF0E1_D2C3, 32'h0000_00F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
